// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: operand/result handshake bundle for seq_multiplier
// signed_mode exists only when SEQ_MULT_SIGNED_EN is defined
interface seq_multiplier_if #(parameter int WIDTH = 16);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] a, b;
  logic [2*WIDTH-1:0] product;
`ifdef SEQ_MULT_SIGNED_EN
  logic signed_mode;
`endif
  modport master (
`ifdef SEQ_MULT_SIGNED_EN
    output signed_mode,
`endif
    output in_valid, a, b, out_ready,
    input in_ready, out_valid, product
  );
  modport slave (
`ifdef SEQ_MULT_SIGNED_EN
    input signed_mode,
`endif
    input in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-add multiplier, WIDTH iterations per result
// defining SEQ_MULT_SIGNED_EN adds two's-complement mode via sign-magnitude
module seq_multiplier #(parameter int WIDTH = 16) (
  input  logic clk,
  input  logic rst,
  seq_multiplier_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [2*WIDTH-1:0] mcand, acc, sum, fin;
  logic [WIDTH-1:0] mplier, a_mag, b_mag;
  logic [CW-1:0] cnt;
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign sum = acc + (mplier[0] ? mcand : '0);
`ifdef SEQ_MULT_SIGNED_EN
  logic neg;
  // magnitude of the most-negative value still fits in WIDTH unsigned bits
  assign a_mag = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign fin = neg ? -sum : sum;
`else
  assign a_mag = bus.a;
  assign b_mag = bus.b;
  assign fin = sum;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      bus.product <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      neg <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          mcand <= {{WIDTH{1'b0}}, a_mag};
          mplier <= b_mag;
          acc <= '0;
          cnt <= CW'(WIDTH);
`ifdef SEQ_MULT_SIGNED_EN
          neg <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
`endif
          state <= BUSY;
        end
        BUSY: begin
          acc <= sum;
          mcand <= mcand << 1;
          mplier <= mplier >> 1;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bus.product <= fin;
            state <= DONE;
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: scoreboard bench for seq_multiplier at WIDTH=16 and WIDTH=8
// signed vectors run only when SEQ_MULT_SIGNED_EN is defined
module tb_seq_multiplier;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  seq_multiplier_if #(16) b16();
  seq_multiplier_if #(8) b8();
  seq_multiplier #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  seq_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));

  typedef struct {logic [63:0] p; int c;} exp_t;
  exp_t q16[$], q8[$];
  int checks = 0, fails = 0, outs16 = 0, push16 = 0;
  logic pv16 = 1'b0, pv8 = 1'b0;

  task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && b16.out_valid && !pv16) begin
      outs16++;
      if (q16.size() == 0) chk("unexpected_result16", 1, 0);
      else begin
        e = q16.pop_front();
        chk("product16", 64'(b16.product), e.p);
        chk("latency16", 64'(cyc - e.c), 16);
      end
    end
    pv16 <= b16.out_valid;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && b8.out_valid && !pv8) begin
      if (q8.size() == 0) chk("unexpected_result8", 1, 0);
      else begin
        e = q8.pop_front();
        chk("product8", 64'(b8.product), e.p);
        chk("latency8", 64'(cyc - e.c), 8);
      end
    end
    pv8 <= b8.out_valid;
  end

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic sm, input logic [63:0] exp);
    int t = 0;
    while (!b16.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!b16.in_ready) chk("in_ready_timeout16", 0, 1);
    b16.in_valid = 1'b1;
    b16.a = a;
    b16.b = b;
`ifdef SEQ_MULT_SIGNED_EN
    b16.signed_mode = sm;
`endif
    q16.push_back('{exp, cyc + 1});
    push16++;
    @(negedge clk);
    b16.in_valid = 1'b0;
    b16.a = 16'h5A5A;
    b16.b = 16'hA5A5;
`ifdef SEQ_MULT_SIGNED_EN
    b16.signed_mode = ~sm;
`endif
  endtask

  task automatic drain16();
    int t = 0;
    while ((q16.size() != 0 || !b16.in_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q16.size() != 0 || !b16.in_ready) chk("drain_timeout16", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;
    int t;
    b16.in_valid = 1'b1;
    b16.a = 16'd3;
    b16.b = 16'd3;
    b16.out_ready = 1'b1;
    b8.in_valid = 1'b1;
    b8.a = 8'd3;
    b8.b = 8'd3;
    b8.out_ready = 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
    b16.signed_mode = 1'b0;
    b8.signed_mode = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 64'(b16.in_ready), 1);
    chk("reset_out_valid", 64'(b16.out_valid), 0);
    chk("reset_product", 64'(b16.product), 0);
    b16.in_valid = 1'b0;
    b8.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 64'(b16.in_ready), 1);

    send16(16'd65535, 16'd65535, 1'b0, 64'd4294836225);
    send16(16'd15, 16'd3, 1'b0, 64'd45);
    send16(16'd0, 16'd0, 1'b0, 64'd0);
    send16(16'd40000, 16'd2, 1'b0, 64'd80000);
    drain16();
`ifdef SEQ_MULT_SIGNED_EN
    send16(16'hFFFF, 16'h0001, 1'b1, 64'hFFFFFFFF);
    send16(16'h8000, 16'h8000, 1'b1, 64'h40000000);
    send16(16'hFFFF, 16'h0001, 1'b0, 64'h0000FFFF);
    send16(16'hFFFD, 16'h0005, 1'b1, 64'hFFFFFFF1);
    drain16();
`endif

    // operands offered while busy must be dropped
    send16(16'd25, 16'd10, 1'b0, 64'd250);
    b16.in_valid = 1'b1;
    b16.a = 16'd7;
    b16.b = 16'd9;
    repeat (4) @(negedge clk);
    chk("busy_in_ready", 64'(b16.in_ready), 0);
    b16.in_valid = 1'b0;
    drain16();
    repeat (20) @(negedge clk);
    chk("result_count", 64'(outs16), 64'(push16));

    b16.out_ready = 1'b0;
    send16(16'd300, 16'd300, 1'b0, 64'd90000);
    t = 0;
    while (!b16.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("hold_reached_done", 64'(b16.out_valid), 1);
    held = b16.product;
    repeat (5) begin
      @(negedge clk);
      chk("hold_out_valid", 64'(b16.out_valid), 1);
      chk("hold_product", 64'(b16.product), 64'(held));
      chk("hold_in_ready", 64'(b16.in_ready), 0);
    end
    b16.out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 64'(b16.in_ready), 1);
    chk("release_out_valid", 64'(b16.out_valid), 0);
    chk("idle_product_kept", 64'(b16.product), 64'd90000);

    send16(16'd123, 16'd45, 1'b0, 64'd5535);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midbusy_rst_in_ready", 64'(b16.in_ready), 1);
    chk("midbusy_rst_out_valid", 64'(b16.out_valid), 0);
    chk("midbusy_rst_product", 64'(b16.product), 0);
    q16.delete();
    push16--;
    rst = 1'b0;
    send16(16'd200, 16'd50, 1'b0, 64'd10000);
    drain16();

    b8.in_valid = 1'b1;
    b8.a = 8'd255;
    b8.b = 8'd255;
    q8.push_back('{64'd65025, cyc + 1});
    @(negedge clk);
    b8.in_valid = 1'b0;
    b8.a = 8'h00;
    t = 0;
    while ((q8.size() != 0 || !b8.in_ready) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (q8.size() != 0) chk("drain_timeout8", 0, 1);
    chk("result_count_final", 64'(outs16), 64'(push16));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; legal range 2..32.
REQ-002 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 IN_VALID  input  1  operand pair on A/B is offered.
REQ-005 IN_READY  output  1  block can accept an operand pair.
REQ-006 A  input  WIDTH  multiplicand.
REQ-007 B  input  WIDTH  multiplier.
REQ-008 SIGNED_MODE  input  1  1 = two's-complement operands; sampled with A/B; present only when SEQ_MULT_SIGNED_EN is defined.
REQ-009 OUT_VALID  output  1  PRODUCT holds a completed result.
REQ-010 OUT_READY  input  1  consumer accepts the result.
REQ-011 PRODUCT  output  2*WIDTH  result of the last accepted operation.

Function
REQ-012 FSM states: IDLE, BUSY, DONE; encoding free.
REQ-013 IDLE: IN_READY=1, OUT_VALID=0; IN_VALID=1 at an edge captures A, B (and SIGNED_MODE), clears accumulator, loads iteration counter, moves to BUSY.
REQ-014 BUSY: radix-2 shift-add, one multiplier bit per edge, exactly WIDTH edges; the last iteration edge loads PRODUCT and moves to DONE.
REQ-015 Latency: OUT_VALID rises exactly WIDTH edges after the accepting edge (16 for default WIDTH), independent of operand values.
REQ-016 DONE: OUT_VALID=1, IN_READY=0; OUT_READY=1 at an edge moves to IDLE; OUT_READY=0 holds DONE indefinitely with PRODUCT stable.
REQ-017 IN_READY=0 in BUSY and DONE; IN_VALID there is ignored, no operand captured, no error flagged.
REQ-018 A/B/SIGNED_MODE changes after the accepting edge do not affect the result in flight.
REQ-019 Unsigned result: exact A*B in 2*WIDTH bits; no overflow possible (max (2^W-1)^2).
REQ-020 PRODUCT changes only on the edge entering DONE; it retains its value through IDLE until the next result.
REQ-021 Back-to-back: a new pair may be accepted no earlier than the edge after the one leaving DONE (IN_READY combinationally from state only, no IN_READY->IN_VALID path issue); throughput one result per WIDTH+2 edges minimum.
REQ-022 OUT_VALID and IN_READY are decoded from registered state only; no combinational path from any input to any output.

Reset
REQ-023 RST=1 at an edge forces IDLE from any state, including mid-BUSY and DONE; the in-flight operation is discarded.
REQ-024 Reset values: IN_READY=1, OUT_VALID=0, PRODUCT=0, counter and accumulator 0.
REQ-025 IN_VALID at the same edge as RST=1 is ignored; first possible accept is the edge after RST deasserts.

Configuration
REQ-026 Macro SEQ_MULT_SIGNED_EN defined: SIGNED_MODE port exists; when sampled 1, operands are two's complement, magnitudes are multiplied and the 2*WIDTH result is negated if operand signs differ; latency unchanged; most-negative x most-negative yields +2^(2*WIDTH-2) exactly.
REQ-027 Macro undefined: no SIGNED_MODE port, no sign logic; block is unsigned-only, behaviour per REQ-019.

Verification
REQ-028 WIDTH=16, A=65535, B=65535 accepted -> OUT_VALID after exactly 16 edges, PRODUCT=4294836225; also 15x3=45, 0x0=0, 40000x2=80000.
REQ-029 WIDTH=16, result ready, OUT_READY held 0 for 5 cycles -> OUT_VALID stays 1, PRODUCT stable, IN_READY 0; OUT_READY=1 -> IDLE next edge.
REQ-030 IN_VALID pulsed with A=7,B=9 during BUSY of 25x10 -> result 250, no second result produced.
REQ-031 RST asserted 5 edges into BUSY -> next edge IDLE, PRODUCT=0, OUT_VALID=0; subsequent 200x50 -> 10000 with full latency.
REQ-032 SEQ_MULT_SIGNED_EN, WIDTH=16, SIGNED_MODE=1: 0xFFFF x 0x0001 -> 0xFFFFFFFF; 0x8000 x 0x8000 -> 0x40000000; SIGNED_MODE=0 on 0xFFFF x 0x0001 -> 0x0000FFFF.
REQ-033 WIDTH=8: 255x255 -> PRODUCT=65025 after exactly 8 edges.
